rv32i_lsu_wbu: RTL and testbench

Memory-access and write-back stage of the RV32I 5-stage pipeline. It sits downstream of the EXU. It performs data-memory loads and stores over a request/grant/response handshake with variable latency. While an access is outstanding it stalls the upstream stages. It produces the registered register-file write port (`we`, `rd` index, `wdata`) that feeds the IDU's write-back inputs.

---
 rtl/rv32i_lsu_wbu.sv | 138 +++++++++++++
 tb/tb_rv32i_lsu_wbu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rv32i_lsu_wbu.sv
// rv32i_lsu_wbu: RV32I memory-access and write-back stage with variable-latency dmem handshake
// Inputs  in_*        : instruction from the EXU, held stable while stall_o is high
// Outputs stall_o     : freezes PC/IF/ID/EX while a memory access is outstanding
// Port    dmem_*      : request/grant/response data-memory interface, word-aligned address
// Outputs wb_*        : registered register-file write port
module rv32i_lsu_wbu #(
    parameter int WORD_WTH    = 32,
    parameter int ADDR_WTH    = 32,
    parameter int WB_MUX_WTH  = 2,
    parameter int REG_INX_WTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid_i,
    input  logic                   in_RegW_EN_i,
    input  logic [WB_MUX_WTH-1:0]  in_RegW_sel_i,
    input  logic                   in_MemW_EN_i,
    input  logic                   in_is_lw_i,
    input  logic [2:0]             in_funct3_i,
    input  logic [WORD_WTH-1:0]    in_alu_res_i,
    input  logic [WORD_WTH-1:0]    in_store_data_i,
    input  logic [REG_INX_WTH-1:0] in_rd_inx_i,
    input  logic [ADDR_WTH-1:0]    in_pc_plus_4_i,
    output logic                   stall_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [ADDR_WTH-1:0]    dmem_addr_o,
    output logic [3:0]             dmem_be_o,
    output logic [WORD_WTH-1:0]    dmem_wdata_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [WORD_WTH-1:0]    dmem_rdata_i,
    output logic                   wb_reg_we_o,
    output logic [REG_INX_WTH-1:0] wb_rd_inx_o,
    output logic [WORD_WTH-1:0]    wb_wdata_o
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
    logic [1:0]             state_q, state_d;
    logic [ADDR_WTH-1:0]    addr_q, addr_d;
    logic [2:0]             f3_q, f3_d;
    logic [REG_INX_WTH-1:0] rd_q, rd_d;
    logic                   st_q, st_d;
    logic [3:0]             be_q, be_d;
    logic [WORD_WTH-1:0]    sd_q, sd_d;
    logic                   we_q, we_d;
    logic [REG_INX_WTH-1:0] wrd_q, wrd_d;
    logic [WORD_WTH-1:0]    wdat_q, wdat_d;
    logic                   mem, done;
    logic [1:0]             off;
    logic [3:0]             be_st;
    logic [WORD_WTH-1:0]    sd_st, ld;
    logic [7:0]             lb;
    logic [15:0]            lh;
    assign mem   = in_valid_i & (in_MemW_EN_i | in_is_lw_i);
    assign off   = in_alu_res_i[1:0];
    assign be_st = in_funct3_i == 3'b000 ? 4'b0001 << off :
                   in_funct3_i == 3'b001 ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    assign sd_st = in_funct3_i == 3'b000 ? {4{in_store_data_i[7:0]}} :
                   in_funct3_i == 3'b001 ? {2{in_store_data_i[15:0]}} : in_store_data_i;
    assign lb    = 8'(dmem_rdata_i >> {addr_q[1:0], 3'b000});
    assign lh    = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    assign ld    = f3_q == 3'b000 ? {{24{lb[7]}}, lb} :
                   f3_q == 3'b100 ? {24'b0, lb} :
                   f3_q == 3'b001 ? {{16{lh[15]}}, lh} :
                   f3_q == 3'b101 ? {16'b0, lh} : dmem_rdata_i;
    // A load completes either on rvalid in WAIT or on rvalid arriving together with its grant
    assign done  = dmem_rvalid_i & ((state_q == WAIT) | (state_q == REQ & dmem_gnt_i & ~st_q));
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        rd_d    = rd_q;
        st_d    = st_q;
        be_d    = be_q;
        sd_d    = sd_q;
        we_d    = 1'b0;
        wrd_d   = wrd_q;
        wdat_d  = wdat_q;
        case (state_q)
            IDLE: if (mem) begin
                state_d = REQ;
                addr_d  = in_alu_res_i;
                f3_d    = in_funct3_i;
                // Folding RegW_EN into the index lets x0 suppression cover loads that never write
                rd_d    = in_RegW_EN_i ? in_rd_inx_i : '0;
                st_d    = in_MemW_EN_i;
                be_d    = be_st;
                sd_d    = sd_st;
            end else if (in_valid_i) begin
                we_d   = in_RegW_EN_i & (in_rd_inx_i != '0);
                wrd_d  = in_rd_inx_i;
                wdat_d = in_RegW_sel_i == 2'd2 ? in_pc_plus_4_i : in_alu_res_i;
            end
            REQ:     if (dmem_gnt_i) state_d = (st_q | dmem_rvalid_i) ? IDLE : WAIT;
            WAIT:    if (dmem_rvalid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done) begin
            we_d   = rd_q != '0;
            wrd_d  = rd_q;
            wdat_d = ld;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            f3_q    <= '0;
            rd_q    <= '0;
            st_q    <= 1'b0;
            be_q    <= '0;
            sd_q    <= '0;
            we_q    <= 1'b0;
            wrd_q   <= '0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            rd_q    <= rd_d;
            st_q    <= st_d;
            be_q    <= be_d;
            sd_q    <= sd_d;
            we_q    <= we_d;
            wrd_q   <= wrd_d;
            wdat_q  <= wdat_d;
        end
    end
    assign stall_o      = state_q != IDLE;
    assign dmem_req_o   = state_q == REQ;
    assign dmem_we_o    = dmem_req_o & st_q;
    assign dmem_addr_o  = {addr_q[ADDR_WTH-1:2], 2'b00};
    assign dmem_be_o    = be_q;
    assign dmem_wdata_o = sd_q;
    assign wb_reg_we_o  = we_q;
    assign wb_rd_inx_o  = wrd_q;
    assign wb_wdata_o   = wdat_q;
endmodule

// File: tb/tb_rv32i_lsu_wbu.sv
// tb_rv32i_lsu_wbu: directed vector table plus randomized ops against a spec-level reference model
module tb_rv32i_lsu_wbu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i, in_RegW_EN_i, in_MemW_EN_i, in_is_lw_i;
    logic [1:0]  in_RegW_sel_i;
    logic [2:0]  in_funct3_i;
    logic [31:0] in_alu_res_i, in_store_data_i, in_pc_plus_4_i;
    logic [4:0]  in_rd_inx_i;
    logic        stall_o, dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i, wb_reg_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i, wb_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [4:0]  wb_rd_inx_o;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    rv32i_lsu_wbu dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_RegW_EN_i(in_RegW_EN_i),
        .in_RegW_sel_i(in_RegW_sel_i), .in_MemW_EN_i(in_MemW_EN_i), .in_is_lw_i(in_is_lw_i),
        .in_funct3_i(in_funct3_i), .in_alu_res_i(in_alu_res_i), .in_store_data_i(in_store_data_i),
        .in_rd_inx_i(in_rd_inx_i), .in_pc_plus_4_i(in_pc_plus_4_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .wb_reg_we_o(wb_reg_we_o),
        .wb_rd_inx_o(wb_rd_inx_o), .wb_wdata_o(wb_wdata_o)
    );
    typedef struct {
        logic        v, regw;
        logic [1:0]  sel;
        logic        memw, lw;
        logic [2:0]  f3;
        logic [31:0] alu, sd;
        logic [4:0]  rd;
        logic [31:0] pc4;
        int          gd, rv;
        logic        spur;
        logic [31:0] rdata;
        logic        x_we;
        logic [31:0] x_wd;
        logic [3:0]  x_be;
        logic [31:0] x_dw;
    } vec_t;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", n, a, e);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 0) return 4'(1 << (a % 4));
        if (f3 == 1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'd15;
    endfunction
    function automatic logic [31:0] m_sd(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 0) return (d % 256) * 32'h01010101;
        if (f3 == 1) return (d % 65536) * 32'h00010001;
        return d;
    endfunction
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
        logic [31:0] b, h;
        b = (r >> (8 * (a % 4))) % 256;
        h = (r >> (16 * ((a / 2) % 2))) % 65536;
        if (f3 == 0) return b >= 128 ? b - 256 : b;
        if (f3 == 4) return b;
        if (f3 == 1) return h >= 32768 ? h - 65536 : h;
        if (f3 == 5) return h;
        return r;
    endfunction
    task automatic exec(input vec_t t);
        logic mem;
        mem = t.v & (t.memw | t.lw);
        in_valid_i = t.v; in_RegW_EN_i = t.regw; in_RegW_sel_i = t.sel; in_MemW_EN_i = t.memw;
        in_is_lw_i = t.lw; in_funct3_i = t.f3; in_alu_res_i = t.alu; in_store_data_i = t.sd;
        in_rd_inx_i = t.rd; in_pc_plus_4_i = t.pc4;
        chk("accept_stall", 32'(stall_o), 0);
        step();
        in_valid_i = 1'b0;
        if (mem) begin
            for (int g = 0; g <= t.gd; g++) begin
                chk("req", 32'(dmem_req_o), 1);
                chk("req_stall", 32'(stall_o), 1);
                chk("req_addr", dmem_addr_o, t.alu & ~32'd3);
                chk("req_we", 32'(dmem_we_o), 32'(t.memw));
                if (t.memw) begin
                    chk("req_be", 32'(dmem_be_o), 32'(t.x_be));
                    chk("req_wdata", dmem_wdata_o, t.x_dw);
                end
                chk("req_no_wb", 32'(wb_reg_we_o), 0);
                dmem_gnt_i = g == t.gd;
                dmem_rvalid_i = (g == t.gd && t.lw) ? t.rv == 0 : t.spur;
                dmem_rdata_i = (g == t.gd && t.lw) ? t.rdata : 32'hDEADBEEF;
                step();
            end
            dmem_gnt_i = 1'b0;
            dmem_rvalid_i = 1'b0;
            if (t.lw) begin
                for (int w = 1; w <= t.rv; w++) begin
                    chk("wait_stall", 32'(stall_o), 1);
                    chk("wait_req", 32'(dmem_req_o), 0);
                    chk("wait_no_wb", 32'(wb_reg_we_o), 0);
                    dmem_rvalid_i = w == t.rv;
                    dmem_rdata_i = t.rdata;
                    step();
                end
                dmem_rvalid_i = 1'b0;
            end
        end
        chk("done_stall", 32'(stall_o), 0);
        chk("wb_we", 32'(wb_reg_we_o), 32'(t.x_we));
        if (t.x_we) begin
            chk("wb_rd", 32'(wb_rd_inx_o), 32'(t.rd));
            chk("wb_wdata", wb_wdata_o, t.x_wd);
        end
    endtask
    vec_t vecs[15];
    initial begin
        vec_t t;
        vecs[0]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 32'h0, 0, 0, 1'b0, 32'h0, 1'b1, 32'h1234, 4'h0, 32'h0};
        vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h55, 32'h0, 5'd0, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd0, 32'h1003, 32'hAB, 5'd0, 32'h0, 2, 0, 1'b1, 32'h0, 1'b0, 32'h0, 4'b1000, 32'hABABABAB};
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd0, 32'h2001, 32'h0, 5'd7, 32'h0, 0, 2, 1'b0, 32'h000080FF, 1'b1, 32'hFFFFFF80, 4'h0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd5, 32'h2002, 32'h0, 5'd9, 32'h0, 0, 0, 1'b0, 32'hBEEF0000, 1'b1, 32'h0000BEEF, 4'h0, 32'h0};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd2, 32'h2000, 32'h0, 5'd10, 32'h0, 0, 0, 1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 4'h0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 3'd0, 32'h999, 32'h0, 5'd1, 32'h104, 0, 0, 1'b0, 32'h0, 1'b1, 32'h104, 4'h0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 3'd0, 32'h77, 32'h0, 5'd4, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd1, 32'h3002, 32'h1234BEEF, 5'd0, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b1100, 32'hBEEFBEEF};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 3'd2, 32'h4000, 32'h11223344, 5'd0, 32'h0, 1, 0, 1'b1, 32'h0, 1'b0, 32'h0, 4'b1111, 32'h11223344};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd1, 32'h2002, 32'h0, 5'd11, 32'h0, 1, 1, 1'b1, 32'h80010000, 1'b1, 32'hFFFF8001, 4'h0, 32'h0};
        vecs[11] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd4, 32'h2003, 32'h0, 5'd12, 32'h0, 0, 1, 1'b0, 32'hF0000000, 1'b1, 32'h000000F0, 4'h0, 32'h0};
        vecs[12] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 3'd2, 32'h2000, 32'h0, 5'd0, 32'h0, 0, 0, 1'b0, 32'h12345678, 1'b0, 32'h0, 4'h0, 32'h0};
        vecs[13] = '{1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 3'd0, 32'hA5A5, 32'h0, 5'd31, 32'h200, 0, 0, 1'b0, 32'h0, 1'b1, 32'hA5A5, 4'h0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 3'd2, 32'h2000, 32'h0, 5'd6, 32'h0, 0, 1, 1'b0, 32'h12345678, 1'b0, 32'h0, 4'h0, 32'h0};
        rst = 1'b1;
        in_valid_i = 1'b0; in_RegW_EN_i = 1'b0; in_RegW_sel_i = 2'd0; in_MemW_EN_i = 1'b0;
        in_is_lw_i = 1'b0; in_funct3_i = 3'd0; in_alu_res_i = 32'h0; in_store_data_i = 32'h0;
        in_rd_inx_i = 5'd0; in_pc_plus_4_i = 32'h0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
        step();
        step();
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_req", 32'(dmem_req_o), 0);
        chk("rst_dwe", 32'(dmem_we_o), 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_be", 32'(dmem_be_o), 0);
        chk("rst_dwdata", dmem_wdata_o, 0);
        chk("rst_wb_we", 32'(wb_reg_we_o), 0);
        chk("rst_wb_rd", 32'(wb_rd_inx_o), 0);
        chk("rst_wb_wdata", wb_wdata_o, 0);
        rst = 1'b0;
        for (int i = 0; i < 15; i++) exec(vecs[i]);
        in_valid_i = 1'b1; in_RegW_EN_i = 1'b1; in_is_lw_i = 1'b1; in_MemW_EN_i = 1'b0;
        in_funct3_i = 3'd2; in_alu_res_i = 32'h5000; in_rd_inx_i = 5'd3;
        step();
        in_valid_i = 1'b0;
        dmem_gnt_i = 1'b1;
        step();
        dmem_gnt_i = 1'b0;
        chk("abort_wait_stall", 32'(stall_o), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_stall", 32'(stall_o), 0);
        chk("abort_req", 32'(dmem_req_o), 0);
        chk("abort_wb_we", 32'(wb_reg_we_o), 0);
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'h00C0FFEE;
        step();
        dmem_rvalid_i = 1'b0;
        chk("late_rvalid_wb_we", 32'(wb_reg_we_o), 0);
        chk("late_rvalid_stall", 32'(stall_o), 0);
        for (int i = 0; i < 300; i++) begin
            int k;
            k = $urandom_range(0, 3);
            t.v = k != 3; t.regw = 1'($urandom); t.memw = k == 1; t.lw = k == 2;
            t.sel = t.lw ? 2'd1 : (($urandom_range(0, 2) == 0) ? 2'd0 : (($urandom_range(0, 1) == 0) ? 2'd2 : 2'd3));
            t.f3 = t.memw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            t.alu = $urandom; t.sd = $urandom; t.rd = 5'($urandom); t.pc4 = $urandom;
            t.gd = $urandom_range(0, 3); t.rv = $urandom_range(0, 3); t.spur = 1'($urandom);
            t.rdata = $urandom;
            t.x_we = t.v & ~t.memw & t.regw & (t.rd != 0);
            t.x_wd = t.lw ? m_load(t.f3, t.alu, t.rdata) : (t.sel == 2 ? t.pc4 : t.alu);
            t.x_be = m_be(t.f3, t.alu);
            t.x_dw = m_sd(t.f3, t.sd);
            exec(t);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
